// File: rtl/click_token_source.sv
// click_token_source: clocked two-phase token generator feeding a click pipeline.
// Emits bursts of increment/LFSR/constant data tokens and handshakes through a synchronised ack.
module click_token_source #(
    parameter int DATA_W = 8,
    parameter int CNT_W = 16,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_tokens,
    input  logic [DATA_W-1:0] i_seed,
    input  logic [1:0]        i_mode,
    input  logic              in_ackR,
    output logic              out_reqR,
    output logic [DATA_W-1:0] out_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_sent_cnt,
    output logic              o_err
);
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic ack_s, ack_d, ack_chg;
    logic [CNT_W-1:0] num_q, cnt_inc;
    logic [1:0] mode_q;
    logic [DATA_W-1:0] next_data;
    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign ack_chg = ack_s ^ ack_d;
    assign cnt_inc = o_sent_cnt + 1'b1;
    // mode 3 falls through to the hold-value branch, same as mode 2
    always_comb next_data = mode_q == 2'd0 ? out_data + 1'b1
                          : mode_q == 2'd1 ? {out_data[DATA_W-2:0], ^(out_data & LFSR_TAPS)}
                          : out_data;
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            ack_sync   <= '0;
            ack_d      <= 1'b0;
            num_q      <= '0;
            mode_q     <= 2'd0;
            out_reqR   <= 1'b0;
            out_data   <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_sent_cnt <= '0;
            o_err      <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], in_ackR};
            ack_d    <= ack_s;
            o_done   <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    o_sent_cnt <= '0;
                    o_busy     <= 1'b1;
                    if (i_num_tokens != '0) begin
                        num_q    <= i_num_tokens;
                        mode_q   <= i_mode;
                        out_data <= (i_mode == 2'd1 && i_seed == '0) ? DATA_W'(1) : i_seed;
                        o_err    <= 1'b0;
                        state    <= SETUP;
                    end else begin
                        state <= DONE;
                    end
                end
                SETUP: begin
                    out_reqR <= ~out_reqR;
                    state    <= WAIT;
                end
                WAIT: if (ack_s == out_reqR) begin
                    o_sent_cnt <= cnt_inc;
                    if (cnt_inc == num_q) begin
                        state <= DONE;
                    end else begin
                        out_data <= next_data;
                        state    <= SETUP;
                    end
                end
                default: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
            // any ack movement outside WAIT cannot be a legitimate completion
            if (ack_chg && state != WAIT) o_err <= 1'b1;
        end
    end
endmodule

// File: doc/click_token_source.md
CLICK_TOKEN_SOURCE -- requirements
Module: click_token_source

Interface
REQ-001 SHALL have parameter DATA_W, default 8, token data width.
REQ-002 SHALL have parameter CNT_W, default 16, token count width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, ack synchroniser depth (min 2).
REQ-004 SHALL have parameter LFSR_TAPS, default 8'hB8, DATA_W-bit Fibonacci LFSR tap mask.
REQ-005 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_start  input  1  start burst (sampled in IDLE only).
REQ-008 SHALL have port i_num_tokens  input  CNT_W  tokens per burst.
REQ-009 SHALL have port i_seed  input  DATA_W  first token value.
REQ-010 SHALL have port i_mode  input  2  data pattern: 0 increment, 1 LFSR, 2 constant, 3 reserved (treated as 2).
REQ-011 SHALL have port in_ackR  input  1  two-phase ack from click pipeline, asynchronous to i_clk.
REQ-012 SHALL have port out_reqR  output  1  two-phase request to click pipeline.
REQ-013 SHALL have port out_data  output  DATA_W  bundled token data.
REQ-014 SHALL have port o_busy  output  1  high in any non-IDLE state.
REQ-015 SHALL have port o_done  output  1  one-cycle pulse at burst end.
REQ-016 SHALL have port o_sent_cnt  output  CNT_W  tokens acknowledged in current/last burst.
REQ-017 SHALL have port o_err  output  1  sticky protocol error flag.

Function
REQ-018 SHALL synchronise in_ackR through SYNC_STAGES flops (reset 0) into ack_s; only ack_s used internally.
REQ-019 SHALL use two-phase protocol: a token is outstanding while out_reqR != ack_s, complete when ack_s == out_reqR.
REQ-020 SHALL implement FSM states IDLE, SETUP, WAIT, DONE.
REQ-021 IDLE: i_start=1 and i_num_tokens!=0 -> latch count, load out_data=i_seed (LFSR mode: seed 0 replaced by 1), clear o_sent_cnt and o_err, go SETUP.
REQ-022 IDLE: i_start=1 and i_num_tokens==0 -> clear o_sent_cnt, go DONE without touching out_reqR.
REQ-023 SETUP lasts exactly one cycle (data setup before request); on exit toggle out_reqR, go WAIT.
REQ-024 WAIT: on ack_s == out_reqR increment o_sent_cnt; if new count == latched count go DONE, else update out_data per mode and go SETUP.
REQ-025 Data update: mode 0 out_data+1 modulo 2^DATA_W (wraps FF->00); mode 1 shift left, LSB = XOR of bits selected by LFSR_TAPS; mode 2 unchanged.
REQ-026 out_data SHALL change only in IDLE->SETUP or WAIT->SETUP transitions, never while a token is outstanding.
REQ-027 DONE: o_done=1 for exactly one cycle, go IDLE.
REQ-028 i_start SHALL be ignored outside IDLE; i_mode, i_seed, i_num_tokens sampled only at accepted start (mode latched).
REQ-029 out_reqR phase SHALL persist across bursts (not re-initialised between bursts).
REQ-030 o_err SHALL set when ack_s changes while in IDLE, SETUP or DONE (spurious ack); it holds until next accepted start.
REQ-031 Minimum per-token time = 1 SETUP cycle + SYNC_STAGES + 1 WAIT cycles with immediate ack.

Reset
REQ-032 On i_rstn low, asynchronously: state IDLE, out_reqR=0, out_data=0, o_sent_cnt=0, o_busy=0, o_done=0, o_err=0, synchroniser flops 0.
REQ-033 Reset mid-burst SHALL abort the burst without o_done; after release block is in IDLE with REQ-032 values.
REQ-034 Environment SHALL hold in_ackR low during reset; a high in_ackR after release is a spurious ack and sets o_err.

Verification
REQ-035 Start, num=4, seed=8'h10, mode 0, pipeline acks each toggle after 3 cycles -> out_data 10,11,12,13, out_reqR toggles 4 times ending 0, o_sent_cnt=4, one o_done pulse.
REQ-036 Mode 1, seed=0, num=3, DATA_W=8, taps B8 -> first token 8'h01, then 8'h02, 8'h04; second burst start with out_reqR=1 toggles it to 0 first.
REQ-037 Mode 0, seed=8'hFE, num=3 -> tokens FE, FF, 00 (wrap).
REQ-038 num=0 start -> o_done pulse two cycles after start, out_reqR unchanged, o_sent_cnt=0.
REQ-039 i_start pulsed while busy, and in_ackR toggled in IDLE -> second start ignored; o_err=1 until next accepted start.
REQ-040 i_rstn low while WAIT with token 2 of 5 outstanding -> all outputs per REQ-032 immediately, no o_done, fresh burst runs normally.
